mem_access_unit: RTL
====================

# mem_access_unit

Initiator for the byte-wide `generic_mem` port. It accepts one word-level load/store request at a time from the CPU datapath, with a size of 1, 2 or 4 bytes. It sequences that request into per-byte `we`/`re` cycles on the memory bus, in little-endian order. It returns the assembled read data, or a store completion, as a single-cycle response. It sits between the CPU load/store stage and `generic_mem`, and replaces the bench-side multi-byte load/read tasks with synthesizable hardware.

## Interface
- ADDR_WIDTH, 8, memory address width; it must match the `generic_mem` `log2_number_of_cells` parameter.
- DATA_WIDTH, 32, CPU-side word width; fixed at 32 and only 32 is supported.
- Memory cell size is fixed at 8 bits.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = illegal.
- req_addr  in  ADDR_WIDTH  byte address of the least significant byte.
- req_wdata  in  32  store data; the low N bytes are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data, zero-extended; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; 1 means the request had an illegal size.
- mem_addr  out  ADDR_WIDTH  byte address to the memory.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte read; valid in the cycle after mem_re is high.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.

## Operation
- States: IDLE, WR, RD, RD_LAST, RESP.
- A request is accepted on the rising edge where req_valid && req_ready. req_ready is high only in IDLE.
- On acceptance the unit latches addr, wdata, size and we. It sets N = 1 << req_size and clears the byte counter k and the read accumulator.
- Illegal size (3): go directly to RESP with resp_err=1 and no memory access.
- WR: each cycle drives mem_we=1, mem_addr=addr+k and mem_wdata=wdata[8k+7:8k], then increments k. After byte N-1 the FSM goes to RESP.
- RD: each cycle drives mem_re=1 and mem_addr=addr+k. The byte returned for k-1 is captured into accumulator bits [8(k-1)+7:8(k-1)]. After byte N-1 the FSM goes to RD_LAST.
- RD_LAST: no strobe. Captures the final byte into bits [8(N-1)+7:8(N-1)], then goes to RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_rdata is the accumulator, with bytes at or above N equal to 0. The FSM returns to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: addr+k wraps and no error is raised.
- Outside a strobe cycle, mem_addr and mem_wdata are driven to 0. mem_we and mem_re are never high together.
- req_* inputs are ignored outside IDLE, and there is no response backpressure.

## Timing
- Reset (rst=0, asynchronous) forces the following regardless of clk:
  - state = IDLE, counter = 0, accumulator = 0.
  - req_ready = 1.
  - resp_valid, resp_err, resp_rdata, mem_we, mem_re, mem_addr and mem_wdata all = 0.
- Reset mid-operation aborts the transfer with no response. Bytes already written remain in memory.
- Cycle 0 is the acceptance edge. A store of N bytes drives mem_we in cycles 1..N, and resp_valid in cycle N+1.
- A load of N bytes drives mem_re in cycles 1..N and resp_valid in cycle N+2.
- Latency from acceptance to resp_valid:
  - byte store: 2, halfword store: 3, word store: 5.
  - byte load: 3, halfword load: 4, word load: 6.
  - error: 1.
- req_ready rises in the cycle after RESP. The earliest next acceptance is the edge ending that cycle, so there is no back-to-back overlap.

## Test plan
- Halfword store: addr 0x00, size 1, wdata 0x00003812 -> mem[0]=0x12, mem[1]=0x38, mem_we high 2 cycles, resp_valid at cycle 3 with err=0.
- Halfword load of the same location: addr 0x00, size 1 -> resp_rdata=0x00003812 at cycle 4; mem_re high 2 cycles.
- Word store then load at addr 0x04 with data 0x78945658:
  - store -> mem[4..7] = 58, 56, 94, 78.
  - load -> resp_rdata = 0x78945658 at cycle 6.
- Wrap-around: word store 0xAABBCCDD at 0xFE -> mem[FE]=DD, mem[FF]=CC, mem[00]=BB, mem[01]=AA. A word load at 0xFE returns 0xAABBCCDD.
- Illegal size 3: no mem_we or mem_re activity; resp_valid with resp_err=1 and resp_rdata=0 one cycle after acceptance.
- Reset mid-operation: start a word store of 0x11223344 at 0x10 and assert rst=0 during the second mem_we cycle -> all outputs 0 immediately, no resp_valid, req_ready=1 after release, mem[0x10]=0x44 retained.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// CPU request/response and byte-wide memory bus for mem_access_unit.
// master: the access unit; slave: CPU datapath plus generic_mem.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  mem_we;
  logic                  mem_re;

  modport master (
    input  req_valid, req_we, req_size,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_addr, mem_wdata,
    output mem_we, mem_re
  );

  modport slave (
    output req_valid, req_we, req_size,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_addr, mem_wdata,
    input  mem_we, mem_re
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sequences 1/2/4-byte load/store requests into little-endian byte cycles.
// Ports: clk, rst (async active-low), bus (mem_access_unit_if.master).
module mem_access_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD      = 3'd2;
  localparam logic [2:0] RD_LAST = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] acc;
  logic [2:0]            k;
  logic [1:0]            n_m1;
  logic                  err;

  // Byte lane of the read data arriving this cycle (issued for k-1).
  logic [2:0] k_prev;
  logic [1:0] cap_lane;
  assign k_prev   = k - 3'd1;
  assign cap_lane = k_prev[1:0];

  // N-1 from the size code: 0->0, 1->1, 2->3.
  logic [1:0] size_n_m1;
  assign size_n_m1 = {bus.req_size[1],
                      bus.req_size[1] | bus.req_size[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      wdata <= '0;
      acc   <= '0;
      k     <= '0;
      n_m1  <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr  <= bus.req_addr;
            wdata <= bus.req_wdata;
            n_m1  <= size_n_m1;
            k     <= '0;
            acc   <= '0;
            err   <= &bus.req_size;
            if (&bus.req_size)
              state <= RESP;
            else if (bus.req_we)
              state <= WR;
            else
              state <= RD;
          end
        end
        WR: begin
          k <= k + 3'd1;
          if (k[1:0] == n_m1)
            state <= RESP;
        end
        RD: begin
          if (k != 3'd0)
            acc[{cap_lane, 3'b000} +: 8] <= bus.mem_rdata;
          k <= k + 3'd1;
          if (k[1:0] == n_m1)
            state <= RD_LAST;
        end
        RD_LAST: begin
          acc[{cap_lane, 3'b000} +: 8] <= bus.mem_rdata;
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] mask;
  always_comb begin
    mask = '1;
    unique case (1'b1)
      (n_m1 == 2'd0): mask = DATA_WIDTH'(32'h0000_00ff);
      (n_m1 == 2'd1): mask = DATA_WIDTH'(32'h0000_ffff);
      default:        mask = '1;
    endcase
  end

  logic st_wr;
  logic st_rd;
  logic st_resp;
  assign st_wr   = (state == WR);
  assign st_rd   = (state == RD);
  assign st_resp = (state == RESP);

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (st_wr || st_rd)
      bus.mem_addr = addr + ADDR_WIDTH'(k);
    if (st_wr)
      bus.mem_wdata = wdata[{k[1:0], 3'b000} +: 8];
  end

  assign bus.mem_we     = st_wr;
  assign bus.mem_re     = st_rd;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = st_resp;
  assign bus.resp_err   = st_resp && err;
  assign bus.resp_rdata = (st_resp && !err) ? (acc & mask) : '0;

endmodule
